// File: rtl/param_elastic_fifo_if.sv
// Handshake and monitoring bundle for param_elastic_fifo.
// The master side is the producer/consumer environment; the slave side is the buffer.
interface param_elastic_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic [CNT_W-1:0]  hwm;
  logic              hwm_clr;

  modport master (
    output in_valid, in_data, out_ready, hwm_clr,
    input  in_ready, out_valid, out_data, count, almost_full, hwm
  );

  modport slave (
    input  in_valid, in_data, out_ready, hwm_clr,
    output in_ready, out_valid, out_data, count, almost_full, hwm
  );
endinterface

// File: rtl/param_elastic_fifo.sv
// First-word-fall-through elastic buffer with occupancy, almost-full and
// clearable high-water-mark reporting.
module param_elastic_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = 3
) (
  input logic                 clk,
  input logic                 rst,
  param_elastic_fifo_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  hwm_r;
  logic              out_valid_r;
  logic              almost_full_r;

  logic              in_ready_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W-1:0]  hwm_next_s;

  // A full buffer refuses input even if a pop frees a slot this cycle.
  assign in_ready_s = !rst && (count_r != CNT_W'(DEPTH));
  assign push_s     = bus.in_valid && in_ready_s;
  assign pop_s      = out_valid_r && bus.out_ready;

  // Next occupancy and high-water mark.
  always_comb begin
    count_next_s = count_r;
    hwm_next_s   = hwm_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    if (bus.hwm_clr) begin
      hwm_next_s = count_next_s;
    end else if (count_next_s > hwm_r) begin
      hwm_next_s = count_next_s;
    end else begin
      hwm_next_s = hwm_r;
    end
  end

  // Control state: pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      hwm_r         <= {CNT_W{1'b0}};
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r       <= count_next_s;
      hwm_r         <= hwm_next_s;
      out_valid_r   <= (count_next_s != {CNT_W{1'b0}});
      almost_full_r <= (count_next_s >= CNT_W'(ALMOST_FULL));
    end
  end

  // Payload storage; no reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = mem_r[rd_ptr_r];
  assign bus.count       = count_r;
  assign bus.almost_full = almost_full_r;
  assign bus.hwm         = hwm_r;
endmodule

// File: doc/param_elastic_fifo.md
# param_elastic_fifo

Synchronous first-word-fall-through elastic buffer with valid/ready handshakes on both sides, configured entirely through typed parameter ports. It sits between a producing stage and a consuming stage and absorbs backpressure bursts of up to DEPTH words. It also reports occupancy, an almost-full flag and a clearable high-water mark for performance monitoring.

## Interface
- parameter int unsigned DATA_W, default 8: payload width in bits; must be 1 or more.
- parameter int unsigned DEPTH, default 4: number of storage entries; must be a power of two and 2 or more.
- parameter int unsigned ALMOST_FULL, default 3: occupancy at or above which almost_full asserts; range 1..DEPTH.
- parameter localparam CNT_W = $clog2(DEPTH+1): width of the occupancy outputs; derived, not overridable.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  buffer accepts a word this cycle.
- in_data  input  DATA_W  write payload.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  DATA_W  head-of-queue payload.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= ALMOST_FULL.
- hwm  output  CNT_W  maximum count since reset or the last hwm_clr.
- hwm_clr  input  1  synchronous clear of hwm.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = !rst & (count != DEPTH). It is combinational and has no dependency on out_ready; a full buffer refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr]. Read is combinational from storage.
- Storage is DEPTH x DATA_W registers with no reset. Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- On push: mem[wr_ptr] <= in_data and wr_ptr increments. On pop: rd_ptr increments.
- count next value: +1 on push only, -1 on pop only, unchanged on both or neither. It never leaves 0..DEPTH.
- hwm next value: if hwm_clr, the next hwm is count_next; otherwise it is max(hwm, count_next). hwm_clr takes priority over the max update.
- Reset (rst high at an edge):
  - wr_ptr, rd_ptr, count and hwm are set to 0.
  - out_valid is 0 and almost_full is 0.
  - in_ready is 0 while rst is high.
  - Reset mid-operation discards all stored words with no pop indication.
  - out_data is don't-care while out_valid is 0.
- Data is never corrupted or reordered. An illegal push attempt (in_valid while in_ready is 0) is simply not accepted; the producer must hold the word.

## Timing
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Throughput: one push and one pop per cycle whenever 0 < count < DEPTH.
- With count == 0, a pop cannot occur. A push in that cycle leaves count = 1.
- With count == DEPTH, a push cannot occur. A pop in that cycle leaves count = DEPTH-1, and in_ready rises the following cycle.
- count, almost_full and hwm are registered-state derived, so they update the cycle after the causing edge.
- The first cycle after rst deasserts: in_ready = 1 and out_valid = 0.

## Test plan
- Reset values: hold rst for 2 cycles with in_valid=1. Required: in_ready=0, out_valid=0, count=0, hwm=0, almost_full=0. After release: in_ready=1.
- Fill and drain, DEPTH=4, ALMOST_FULL=3: push 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - almost_full rises when count=3; in_ready=0 when count=4; hwm=4.
  - Then out_ready=1: pops 0x11, 0x22, 0x33, 0x44 in order on consecutive cycles, ending with count=0.
- Full with simultaneous attempt: at count=4 drive in_valid=1, in_data=0x55 and out_ready=1.
  - 0x11 pops and 0x55 is not accepted; count=3.
  - Next cycle 0x55 is accepted; later pops yield 0x22, 0x33, 0x44, 0x55.
- Wrap-around streaming: hold in_valid=1 and out_ready=1 with an incrementing payload for 20 cycles starting empty.
  - count settles at 1.
  - Outputs are 0..18 in order with no gaps, and pointers pass index 3 to 0 repeatedly.
- hwm clear: reach count=3, pop to count=1, then pulse hwm_clr with no push or pop.
  - hwm is 3 before the pulse and 1 after.
  - A subsequent push gives hwm=2.
- Reset mid-operation: with count=2 (0xAA, 0xBB), assert rst for 1 cycle while out_ready=0.
  - Required: count=0 and out_valid=0.
  - A next push of 0xCC appears as the first output.
